// File: rtl/picomips_pkg.sv
// Shared opcodes, ALU codes, flag indices and sequencer states for the picoMIPS control path.
package picomips_pkg;

  localparam int unsigned OPW_DEF  = 6;
  localparam int unsigned ALUW_DEF = 3;

  // Low three opcode bits double as the ALU function code.
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h0A;
  localparam logic [5:0] OP_SUBI = 6'h0B;
  localparam logic [5:0] OP_BEQ  = 6'h10;
  localparam logic [5:0] OP_BNE  = 6'h11;
  localparam logic [5:0] OP_BLT  = 6'h12;
  localparam logic [5:0] OP_J    = 6'h18;
  localparam logic [5:0] OP_WAIT = 6'h20;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    EXEC,
    MUL_BUSY,
    IO_WAIT
  } ctrl_state_t;

endpackage

// File: rtl/picomips_br_cond.sv
// Branch-condition evaluator: decides whether a conditional branch opcode is taken.
module picomips_br_cond
  import picomips_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic [OPW-1:0] opcode,
  input  logic [3:0]     flags,
  output logic           take
);

  // Carry is not consulted by any branch in this ISA.
  logic unused_carry;
  assign unused_carry = flags[FLAG_C];

  always_comb begin
    take = 1'b0;
    if (opcode == OPW'(OP_BEQ)) begin
      take = flags[FLAG_Z];
    end else if (opcode == OPW'(OP_BNE)) begin
      take = ~flags[FLAG_Z];
    end else if (opcode == OPW'(OP_BLT)) begin
      take = flags[FLAG_N] ^ flags[FLAG_V];
    end
  end

endmodule

// File: rtl/picomips_ctrl_seq.sv
// picoMIPS instruction decoder with a sequencer for multi-cycle MUL, WAIT handshake and branches.
module picomips_ctrl_seq
  import picomips_pkg::*;
#(
  parameter int unsigned OPW     = OPW_DEF,
  parameter int unsigned ALUW    = ALUW_DEF,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      flags,
  input  logic            io_ready,
  output logic            PCincr,
  output logic            PCabsbranch,
  output logic            PCrelbranch,
  output logic [ALUW-1:0] ALUfunc,
  output logic            imm,
  output logic            w,
  output logic            mul_start,
  output logic            io_ack,
  output logic            stall,
  output logic            illegal
);

  localparam int unsigned CNTW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  ctrl_state_t     state_q, state_d;
  logic [CNTW-1:0] mul_cnt_q, mul_cnt_d;
  logic            illegal_q, illegal_d;

  logic            br_take;
  logic            pc_incr, pc_abs, pc_rel, imm_sel, wr_en, mul_go, ack, hold;
  logic [ALUW-1:0] alu_fn;

  picomips_br_cond #(
    .OPW (OPW)
  ) u_br_cond (
    .opcode (opcode),
    .flags  (flags),
    .take   (br_take)
  );

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    illegal_d = illegal_q;
    pc_incr   = 1'b1;
    pc_abs    = 1'b0;
    pc_rel    = 1'b0;
    alu_fn    = opcode[ALUW-1:0];
    imm_sel   = 1'b0;
    wr_en     = 1'b0;
    mul_go    = 1'b0;
    ack       = 1'b0;
    hold      = 1'b0;

    unique case (state_q)
      EXEC: begin
        if (opcode == OPW'(OP_NOP)) begin
          // defaults
        end else if (opcode == OPW'(OP_ADD) || opcode == OPW'(OP_SUB)) begin
          wr_en = 1'b1;
        end else if (opcode == OPW'(OP_ADDI) || opcode == OPW'(OP_SUBI)) begin
          wr_en   = 1'b1;
          imm_sel = 1'b1;
        end else if (opcode == OPW'(OP_MUL)) begin
          if (MUL_LAT == 0) begin
            wr_en = 1'b1;
          end else begin
            mul_go    = 1'b1;
            hold      = 1'b1;
            pc_incr   = 1'b0;
            mul_cnt_d = CNTW'(MUL_LAT - 1);
            state_d   = MUL_BUSY;
          end
        end else if (opcode == OPW'(OP_BEQ) || opcode == OPW'(OP_BNE) ||
                     opcode == OPW'(OP_BLT)) begin
          pc_rel  = br_take;
          pc_incr = ~br_take;
        end else if (opcode == OPW'(OP_J)) begin
          pc_abs  = 1'b1;
          pc_incr = 1'b0;
        end else if (opcode == OPW'(OP_WAIT)) begin
          if (io_ready) begin
            ack = 1'b1;
          end else begin
            hold    = 1'b1;
            pc_incr = 1'b0;
            state_d = IO_WAIT;
          end
        end else begin
          illegal_d = 1'b1;
        end
      end
      MUL_BUSY: begin
        // Opcode is ignored here; the ALU keeps computing the multiply.
        alu_fn = ALUW'(ALU_MUL);
        if (mul_cnt_q != '0) begin
          hold      = 1'b1;
          pc_incr   = 1'b0;
          mul_cnt_d = mul_cnt_q - CNTW'(1);
        end else begin
          wr_en   = 1'b1;
          state_d = EXEC;
        end
      end
      IO_WAIT: begin
        if (io_ready) begin
          ack     = 1'b1;
          state_d = EXEC;
        end else begin
          hold    = 1'b1;
          pc_incr = 1'b0;
        end
      end
      default: begin
        state_d = EXEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= EXEC;
      mul_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Every output is forced low while reset is held, including PCincr.
  assign PCincr      = n_reset & pc_incr;
  assign PCabsbranch = n_reset & pc_abs;
  assign PCrelbranch = n_reset & pc_rel;
  assign ALUfunc     = n_reset ? alu_fn : '0;
  assign imm         = n_reset & imm_sel;
  assign w           = n_reset & wr_en;
  assign mul_start   = n_reset & mul_go;
  assign io_ack      = n_reset & ack;
  assign stall       = n_reset & hold;
  assign illegal     = n_reset & illegal_q;

endmodule

// File: tb/tb_picomips_ctrl_seq.sv
// Directed bench for picomips_ctrl_seq: one instance with MUL_LAT=2, one with MUL_LAT=0.
module tb_picomips_ctrl_seq;
  import picomips_pkg::*;

  logic       clk;
  logic       n_reset;
  logic [5:0] opcode;
  logic [3:0] flags;
  logic       io_ready;

  logic       pc_incr, pc_abs, pc_rel, imm, w, mul_start, io_ack, stall, illegal;
  logic [2:0] alu_func;
  logic       z_pc_incr, z_pc_abs, z_pc_rel, z_imm, z_w, z_mul_start, z_io_ack, z_stall;
  logic       z_illegal;
  logic [2:0] z_alu_func;

  int n_checks = 0;
  int n_fail   = 0;

  picomips_ctrl_seq #(
    .OPW     (6),
    .ALUW    (3),
    .MUL_LAT (2)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .opcode      (opcode),
    .flags       (flags),
    .io_ready    (io_ready),
    .PCincr      (pc_incr),
    .PCabsbranch (pc_abs),
    .PCrelbranch (pc_rel),
    .ALUfunc     (alu_func),
    .imm         (imm),
    .w           (w),
    .mul_start   (mul_start),
    .io_ack      (io_ack),
    .stall       (stall),
    .illegal     (illegal)
  );

  picomips_ctrl_seq #(
    .OPW     (6),
    .ALUW    (3),
    .MUL_LAT (0)
  ) dut0 (
    .clk         (clk),
    .n_reset     (n_reset),
    .opcode      (opcode),
    .flags       (flags),
    .io_ready    (io_ready),
    .PCincr      (z_pc_incr),
    .PCabsbranch (z_pc_abs),
    .PCrelbranch (z_pc_rel),
    .ALUfunc     (z_alu_func),
    .imm         (z_imm),
    .w           (z_w),
    .mul_start   (z_mul_start),
    .io_ack      (z_io_ack),
    .stall       (z_stall),
    .illegal     (z_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {PCincr, PCabsbranch, PCrelbranch, imm, w, mul_start, io_ack, stall, illegal}
  logic [8:0] outs, z_outs;
  assign outs   = {pc_incr, pc_abs, pc_rel, imm, w, mul_start, io_ack, stall, illegal};
  assign z_outs = {z_pc_incr, z_pc_abs, z_pc_rel, z_imm, z_w, z_mul_start, z_io_ack, z_stall,
                   z_illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [8:0] exp, input logic [2:0] exp_alu);
    check_eq({tag, ".outs"}, 32'(outs), 32'(exp));
    check_eq({tag, ".alu"}, 32'(alu_func), 32'(exp_alu));
  endtask

  // Apply inputs just after the falling edge and sample mid-cycle.
  task automatic cyc(input logic [5:0] op, input logic [3:0] fl, input logic rdy);
    @(negedge clk);
    opcode   = op;
    flags    = fl;
    io_ready = rdy;
    #1;
  endtask

  initial begin
    n_reset  = 1'b0;
    opcode   = OP_ADD;
    flags    = 4'b0000;
    io_ready = 1'b0;
    #3;
    expect_outs("rst_early", 9'b000000000, 3'b000);
    repeat (2) @(posedge clk);
    #2;
    expect_outs("rst_held", 9'b000000000, 3'b000);
    check_eq("rst_held.dut0", 32'(z_outs), 32'h0);

    @(negedge clk);
    n_reset = 1'b1;
    #1;
    expect_outs("add", 9'b100010000, 3'b010);
    cyc(OP_ADDI, 4'b0000, 1'b0);
    expect_outs("addi", 9'b100110000, 3'b010);
    cyc(OP_SUB, 4'b0000, 1'b0);
    expect_outs("sub", 9'b100010000, 3'b011);

    // MUL, three cycles on the MUL_LAT=2 instance, one on the MUL_LAT=0 instance
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mul_c0", 9'b000001010, 3'b100);
    check_eq("mul0_c0", 32'(z_outs), 32'(9'b100010000));
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mul_c1", 9'b000000010, 3'b100);
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mul_c2", 9'b100010000, 3'b100);
    cyc(OP_ADD, 4'b0000, 1'b0);
    expect_outs("after_mul", 9'b100010000, 3'b010);

    // Branches and jump
    cyc(OP_BEQ, 4'b0001, 1'b0);
    expect_outs("beq_t", 9'b001000000, 3'b000);
    cyc(OP_BEQ, 4'b0000, 1'b0);
    expect_outs("beq_nt", 9'b100000000, 3'b000);
    cyc(OP_BNE, 4'b0000, 1'b0);
    expect_outs("bne_t", 9'b001000000, 3'b001);
    cyc(OP_BNE, 4'b0001, 1'b0);
    expect_outs("bne_nt", 9'b100000000, 3'b001);
    cyc(OP_BLT, 4'b0100, 1'b0);
    expect_outs("blt_t", 9'b001000000, 3'b010);
    cyc(OP_BLT, 4'b1100, 1'b0);
    expect_outs("blt_nt", 9'b100000000, 3'b010);
    cyc(OP_J, 4'b0000, 1'b0);
    expect_outs("j", 9'b010000000, 3'b000);

    // WAIT with io_ready low for five cycles
    for (int i = 0; i < 5; i++) begin
      cyc(OP_WAIT, 4'b0000, 1'b0);
      check_eq($sformatf("wait_stall%0d", i), 32'(outs), 32'(9'b000000010));
    end
    cyc(OP_WAIT, 4'b0000, 1'b1);
    expect_outs("wait_ack", 9'b100000100, 3'b000);
    cyc(OP_NOP, 4'b0000, 1'b1);
    expect_outs("wait_done", 9'b100000000, 3'b000);
    cyc(OP_WAIT, 4'b0000, 1'b1);
    expect_outs("wait_rdy", 9'b100000100, 3'b000);
    cyc(OP_NOP, 4'b0000, 1'b0);
    expect_outs("wait_rdy_done", 9'b100000000, 3'b000);

    // Reset during MUL_BUSY aborts the multiply
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mulab_c0", 9'b000001010, 3'b100);
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mulab_c1", 9'b000000010, 3'b100);
    n_reset = 1'b0;
    #1;
    expect_outs("mulab_rst", 9'b000000000, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_eq("mulab_rst_hold", 32'(outs), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    expect_outs("mulre_c0", 9'b000001010, 3'b100);
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mulre_c1", 9'b000000010, 3'b100);
    cyc(OP_MUL, 4'b0000, 1'b0);
    expect_outs("mulre_c2", 9'b100010000, 3'b100);

    // Undefined opcode: acts as NOP, then illegal sticks until reset
    cyc(6'h3F, 4'b0000, 1'b0);
    expect_outs("ill_nop", 9'b100000000, 3'b111);
    cyc(OP_ADD, 4'b0000, 1'b0);
    expect_outs("ill_add1", 9'b100010001, 3'b010);
    cyc(OP_ADD, 4'b0000, 1'b0);
    expect_outs("ill_add2", 9'b100010001, 3'b010);
    n_reset = 1'b0;
    #1;
    check_eq("ill_rst", 32'(outs), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    expect_outs("ill_cleared", 9'b100010000, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/picomips_ctrl_seq.md
Name: picomips_ctrl_seq

Overview:
- Parametrised successor to the picoMIPS single-cycle instruction decoder.
- Adds a small sequencer for three cases:
  - multi-cycle MUL, with a stall and a late register write;
  - WAIT-for-input handshake, used by the matrix-calculation program to wait for switch data;
  - conditional relative branches and absolute jumps, evaluated from ALU flags.
- Sits between instruction memory (opcode field) and the PC, ALU, immediate mux and register file.

Parameters:
- OPW, 6, opcode width (top OPW bits of the instruction).
- ALUW, 3, ALU function width; ALUfunc = opcode[ALUW-1:0].
- MUL_LAT, 2, extra cycles MUL needs (0 = single-cycle MUL, legal range 0..15).
- CNTW, $clog2(MUL_LAT+1) (min 1), local parameter, MUL counter width.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- opcode  in  OPW  current instruction opcode; held stable by the PC while stall=1.
- flags  in  4  ALU flags {V,N,C,Z} (bit0 = Z) from the previous ALU operation.
- io_ready  in  1  level, input data valid (switch handshake).
- PCincr  out  1  PC += 1.
- PCabsbranch  out  1  PC <= immediate.
- PCrelbranch  out  1  PC += immediate.
- ALUfunc  out  ALUW  ALU operation select.
- imm  out  1  select immediate as ALU operand B.
- w  out  1  register-file write enable.
- mul_start  out  1  one-cycle pulse that starts the multiplier.
- io_ack  out  1  one-cycle pulse when WAIT consumes io_ready.
- stall  out  1  instruction is held; PC frozen.
- illegal  out  1  sticky, set on an undefined opcode.

Behaviour:
- FSM states: EXEC, MUL_BUSY, IO_WAIT. Registers: state, mul_cnt (CNTW bits), illegal. All other outputs are combinational from state, opcode, flags and io_ready.
- Reset (n_reset=0, async):
  - state=EXEC, mul_cnt=0, illegal=0.
  - While n_reset=0, all outputs are forced to 0, including PCincr.
- Defaults in every state: PCincr=1, other PC controls 0, ALUfunc=opcode[ALUW-1:0], imm=w=mul_start=io_ack=stall=0.
- Exactly one of PCincr/PCabsbranch/PCrelbranch is 1 whenever stall=0 and reset is released. All three are 0 while stall=1.
- EXEC decode:
  - NOP: defaults.
  - ADD, SUB: w=1.
  - ADDI, SUBI: w=1, imm=1.
  - MUL with MUL_LAT=0: w=1.
  - MUL with MUL_LAT>0: mul_start=1, stall=1, w=0; mul_cnt<=MUL_LAT-1; next state MUL_BUSY.
  - BEQ/BNE/BLT: condition is Z, !Z, N^V respectively. If true: PCrelbranch=1, PCincr=0. If false: PCincr=1.
  - J: PCabsbranch=1, PCincr=0.
  - WAIT with io_ready=1: io_ack=1, PCincr=1, stay in EXEC.
  - WAIT with io_ready=0: stall=1, next state IO_WAIT.
  - Any other opcode: executes as NOP; illegal<=1 on the next clock.
- MUL_BUSY:
  - stall=1, ALUfunc holds the MUL code.
  - If mul_cnt!=0: decrement.
  - If mul_cnt==0: w=1, stall=0, PCincr=1; next state EXEC.
  - Total MUL latency = MUL_LAT+1 cycles.
- IO_WAIT:
  - stall=1 while io_ready=0.
  - On the first cycle io_ready=1: io_ack=1, PCincr=1, stall=0; next state EXEC.
- flags are sampled only in EXEC. An opcode change during stall is a protocol violation and is ignored (state is held).
- Async reset mid-MUL or mid-WAIT aborts the operation: no w pulse, and state returns to EXEC.
- illegal stays at 1 until reset.

Decomposition:
- Package picomips_pkg:
  - OPW/ALUW defaults.
  - Opcode localparams (low 3 bits = ALU code):
    - NOP 6'h00, ADD 6'h02, SUB 6'h03, MUL 6'h04.
    - ADDI 6'h0A, SUBI 6'h0B.
    - BEQ 6'h10, BNE 6'h11, BLT 6'h12.
    - J 6'h18, WAIT 6'h20.
  - ALU codes: ADD 3'b010, SUB 3'b011, MUL 3'b100.
  - typedef enum logic [1:0] ctrl_state_t {EXEC, MUL_BUSY, IO_WAIT}.
  - Flag index constants: Z=0, C=1, N=2, V=3.
- One sub-module, picomips_br_cond: combinational branch-condition evaluator taking (opcode, flags) and producing take. The FSM plus decode stays in the top module.

Test Plan:
- Reset with opcode=ADD: all outputs 0 during reset. After release: PCincr=1, w=1, ALUfunc=3'b010, stall=0. ADDI: additionally imm=1.
- MUL_LAT=2, opcode=MUL:
  - cycle0: mul_start=1, stall=1.
  - cycle1: stall=1.
  - cycle2: w=1, PCincr=1, stall=0.
  - Rerun with MUL_LAT=0: w=1 in cycle0, no mul_start.
- Branches:
  - BEQ, flags=4'b0001 -> PCrelbranch=1, PCincr=0.
  - BEQ, flags=0 -> PCincr=1.
  - BLT, flags=4'b0100 (N=1, V=0) -> PCrelbranch=1.
  - BLT, flags=4'b1100 -> PCincr=1.
  - J -> PCabsbranch=1.
- WAIT with io_ready=0 for 5 cycles, then 1 -> stall=1 for 5 cycles, then io_ack=1 and PCincr=1 for exactly one cycle. WAIT with io_ready already 1 -> completes in 1 cycle.
- opcode=6'h3F -> behaves as NOP; illegal=1 from the next cycle and stays 1 across ADD instructions until n_reset pulses low.
- n_reset asserted in MUL_BUSY cycle1 -> outputs 0 immediately, no w pulse; after release, state=EXEC and the next MUL takes the full MUL_LAT+1 cycles.
